// File: rtl/monitor_nios2_processor_debug_scan_master_if.sv
// Request/response bus between the monitor (master) and the scan sequencer (slave).
interface monitor_nios2_processor_debug_scan_master_if #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [IR_WIDTH-1:0] req_ir;
  logic [DR_WIDTH-1:0] req_data;
  logic                req_ir_only;
  logic                rsp_valid;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  modport master (
    output req_valid, req_ir, req_data, req_ir_only,
    input  req_ready, rsp_valid, rsp_data, rsp_ir_out
  );

  modport slave (
    input  req_valid, req_ir, req_data, req_ir_only,
    output req_ready, rsp_valid, rsp_data, rsp_ir_out
  );
endinterface

// File: rtl/monitor_nios2_processor_debug_scan_master.sv
// Virtual-JTAG scan sequencer: turns one IR/DR request into the UIR/CDR/SDR/UDR strobe
// sequence on a divided vji_tck, shifting the payload out and capturing vji_tdo.
module monitor_nios2_processor_debug_scan_master #(
  parameter int unsigned DR_WIDTH = 38,
  parameter int unsigned IR_WIDTH = 2,
  parameter int unsigned TCK_DIV  = 2
) (
  input  logic                clk,
  input  logic                reset,
  monitor_nios2_processor_debug_scan_master_if.slave bus,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_rti,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr
);

  localparam int unsigned CntW     = $clog2(DR_WIDTH + 1);
  localparam logic [7:0]  HalfInit = 8'(TCK_DIV - 1);

  typedef enum logic [2:0] {StIdle, StUir, StCdr, StSdr, StUdr, StResp} state_e;

  state_e              state_q, state_d;
  logic [7:0]          hcnt_q, hcnt_d;
  logic                tck_q, tck_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DR_WIDTH-1:0] tx_q, tx_d;
  logic [DR_WIDTH-1:0] cap_q, cap_d;
  logic [DR_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IR_WIDTH-1:0] ir_in_q, ir_in_d;
  logic [IR_WIDTH-1:0] rsp_ir_q, rsp_ir_d;
  logic                ir_only_q, ir_only_d;

  logic busy;
  logic rise;
  logic period_end;

  assign busy = (state_q == StUir) || (state_q == StCdr) || (state_q == StSdr) ||
                (state_q == StUdr);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      hcnt_q     <= '0;
      tck_q      <= 1'b0;
      bit_cnt_q  <= '0;
      tx_q       <= '0;
      cap_q      <= '0;
      rsp_data_q <= '0;
      ir_in_q    <= '0;
      rsp_ir_q   <= '0;
      ir_only_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hcnt_q     <= hcnt_d;
      tck_q      <= tck_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_q       <= tx_d;
      cap_q      <= cap_d;
      rsp_data_q <= rsp_data_d;
      ir_in_q    <= ir_in_d;
      rsp_ir_q   <= rsp_ir_d;
      ir_only_q  <= ir_only_d;
    end
  end

  // Tck divider, sequencing and shift/capture next-state logic.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    tck_d      = tck_q;
    bit_cnt_d  = bit_cnt_q;
    tx_d       = tx_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;
    ir_in_d    = ir_in_q;
    rsp_ir_d   = rsp_ir_q;
    ir_only_d  = ir_only_q;
    rise       = 1'b0;
    period_end = 1'b0;

    // Each half-period ends when the counter hits zero; the falling half-end closes the period.
    if (busy) begin
      if (hcnt_q == 8'd0) begin
        hcnt_d     = HalfInit;
        tck_d      = ~tck_q;
        rise       = ~tck_q;
        period_end = tck_q;
      end else begin
        hcnt_d = hcnt_q - 8'd1;
      end
    end

    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          ir_in_d   = bus.req_ir;
          tx_d      = bus.req_data;
          ir_only_d = bus.req_ir_only;
          hcnt_d    = HalfInit;
          tck_d     = 1'b0;
          state_d   = StUir;
        end
      end
      StUir: begin
        if (period_end) begin
          rsp_ir_d = vji_ir_out;
          state_d  = ir_only_q ? StResp : StCdr;
        end
      end
      StCdr: begin
        if (period_end) begin
          bit_cnt_d = CntW'(DR_WIDTH);
          state_d   = StSdr;
        end
      end
      StSdr: begin
        if (rise) begin
          cap_d = {vji_tdo, cap_q[DR_WIDTH-1:1]};
        end
        if (period_end) begin
          tx_d      = tx_q >> 1;
          bit_cnt_d = bit_cnt_q - CntW'(1);
          if (bit_cnt_q == CntW'(1)) begin
            state_d = StUdr;
          end
        end
      end
      StUdr: begin
        // Load the response word on entry to RESP so it is valid alongside the pulse.
        if (period_end) begin
          rsp_data_d = cap_q;
          state_d    = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign vji_tck        = tck_q;
  assign vji_tdi        = (state_q == StSdr) & tx_q[0];
  assign vji_ir_in      = ir_in_q;
  assign vji_rti        = (state_q == StIdle);
  assign vji_uir        = (state_q == StUir);
  assign vji_cdr        = (state_q == StCdr);
  assign vji_sdr        = (state_q == StSdr);
  assign vji_udr        = (state_q == StUdr);
  assign bus.req_ready  = (state_q == StIdle);
  assign bus.rsp_valid  = (state_q == StResp);
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_ir_out = rsp_ir_q;

endmodule

// File: tb/tb_monitor_nios2_processor_debug_scan_master.sv
// Scoreboard bench: random requests against a behavioural virtual-JTAG slave, with a
// monitor that checks each response against the expected latency, data and strobe counts.
module tb_monitor_nios2_processor_debug_scan_master;
  localparam int unsigned DW = 38;
  localparam int unsigned IW = 2;
  localparam int unsigned TD = 2;
  localparam int unsigned P  = 2 * TD;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  monitor_nios2_processor_debug_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) bus ();
  monitor_nios2_processor_debug_scan_master_if #(.DR_WIDTH(DW), .IR_WIDTH(IW)) bus2 ();

  logic          tck, tdi, tdo, rti, uir, cdr, sdr, udr;
  logic [IW-1:0] ir_in, ir_out;
  logic          tck2, tdi2, rti2, uir2, cdr2, sdr2, udr2;
  logic [IW-1:0] ir_in2;
  logic          tdo2 = 1'b0;
  logic [IW-1:0] ir_out2 = '0;

  monitor_nios2_processor_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(TD)) u_dut (
    .clk(clk), .reset(rst), .bus(bus),
    .vji_tck(tck), .vji_tdi(tdi), .vji_tdo(tdo), .vji_ir_in(ir_in), .vji_ir_out(ir_out),
    .vji_rti(rti), .vji_uir(uir), .vji_cdr(cdr), .vji_sdr(sdr), .vji_udr(udr)
  );

  monitor_nios2_processor_debug_scan_master #(.DR_WIDTH(DW), .IR_WIDTH(IW), .TCK_DIV(1)) u_dut2 (
    .clk(clk), .reset(rst), .bus(bus2),
    .vji_tck(tck2), .vji_tdi(tdi2), .vji_tdo(tdo2), .vji_ir_in(ir_in2), .vji_ir_out(ir_out2),
    .vji_rti(rti2), .vji_uir(uir2), .vji_cdr(cdr2), .vji_sdr(sdr2), .vji_udr(udr2)
  );

  // Behavioural slave: loads on the cdr tck rise, shifts tdi in on each sdr tck rise.
  logic [DW-1:0] slave_sr = '0;
  logic [DW-1:0] slave_load;
  logic [IW-1:0] slave_ir_out;
  always @(posedge tck) begin
    if (cdr)      slave_sr <= slave_load;
    else if (sdr) slave_sr <= {tdi, slave_sr[DW-1:1]};
  end
  assign tdo    = slave_sr[0];
  assign ir_out = slave_ir_out;

  typedef struct {
    int unsigned   acc;
    bit            ir_only;
    logic [DW-1:0] data;
    logic [IW-1:0] ir;
    logic [DW-1:0] load;
    logic [IW-1:0] irout;
  } exp_t;

  exp_t          q[$];
  int unsigned   cyc = 0;
  int unsigned   last_acc = 0;
  int unsigned   last_rsp = 0;
  int            tests = 0;
  int            fails = 0;
  bit            prev_held = 1'b0;
  logic [DW-1:0] model_rsp = '0;
  int unsigned   n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle label: the value of cyc seen between edges; the accept cycle is the one before its edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && bus.req_valid && bus.req_ready) begin
      q.push_back('{acc: cyc - 1, ir_only: bus.req_ir_only, data: bus.req_data, ir: bus.req_ir,
                    load: slave_load, irout: slave_ir_out});
      last_acc = cyc - 1;
    end
  end

  // Monitor: strobe exclusivity every cycle, full response check on each rsp_valid.
  always @(negedge clk) begin
    if (!rst) begin
      check("strobe_onehot", int'(rti) + int'(uir) + int'(cdr) + int'(sdr) + int'(udr),
            bus.rsp_valid ? 0 : 1);
      if (rti) check("idle_tck", tck, 1'b0);
      if (uir) n_uir++;
      if (cdr) n_cdr++;
      if (sdr) n_sdr++;
      if (udr) n_udr++;
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (!e.ir_only) model_rsp = e.load;
          check("rsp_cycle", cyc, e.acc + (e.ir_only ? 1 + P : 1 + (DW + 3) * P));
          check("rsp_data", bus.rsp_data, model_rsp);
          check("rsp_ir_out", bus.rsp_ir_out, e.irout);
          check("vji_ir_in", ir_in, e.ir);
          check("uir_cycles", n_uir, P);
          check("cdr_cycles", n_cdr, e.ir_only ? 0 : P);
          check("sdr_cycles", n_sdr, e.ir_only ? 0 : DW * P);
          check("udr_cycles", n_udr, e.ir_only ? 0 : P);
          if (!e.ir_only) check("slave_sr", slave_sr, e.data);
        end
        n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
        last_rsp = cyc;
      end
    end
  end

  task automatic check_reset_values();
    check("rst_req_ready", bus.req_ready, 1'b1);
    check("rst_rti", rti, 1'b1);
    check("rst_strobes", {uir, cdr, sdr, udr, tck, tdi, bus.rsp_valid}, '0);
    check("rst_ir_in", ir_in, '0);
    check("rst_rsp_ir_out", bus.rsp_ir_out, '0);
    check("rst_rsp_data", bus.rsp_data, '0);
  endtask

  task automatic send(input logic [IW-1:0] ir, input logic [DW-1:0] data, input bit ir_only,
                      input logic [DW-1:0] load, input logic [IW-1:0] irout, input bit hold);
    int n = 0;
    while (!bus.req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", bus.req_ready, 1'b1);
    slave_load      = load;
    slave_ir_out    = irout;
    bus.req_valid   = 1'b1;
    bus.req_ir      = ir;
    bus.req_data    = data;
    bus.req_ir_only = ir_only;
    @(posedge clk);
    #1;
    check("accepted", bus.req_ready, 1'b0);
    if (prev_held) check("b2b_accept", last_acc, last_rsp + 1);
    prev_held = hold;
    if (hold) begin
      // Different request held while busy; it must be ignored until ready returns.
      bus.req_data = ~data;
      bus.req_ir   = ~ir;
    end else begin
      bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain", q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] d, l;
    bit            io, hold;
    int            n, first_hi, hi_cnt, n_sdr2;

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_ir = '0; bus.req_data = '0; bus.req_ir_only = 1'b0;
    bus2.req_valid = 1'b0; bus2.req_ir = '0; bus2.req_data = '0; bus2.req_ir_only = 1'b0;
    slave_load = '0; slave_ir_out = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst = 1'b0;

    send(2'b01, 38'h15_5555_5555, 1'b0, 38'h2A_AAAA_AAAA, 2'b00, 1'b0);
    drain();
    send(2'b10, DW'({$urandom(), $urandom()}), 1'b1, DW'({$urandom(), $urandom()}), 2'b11, 1'b0);
    drain();

    for (int i = 0; i < 10; i++) begin
      d    = DW'({$urandom(), $urandom()});
      l    = DW'({$urandom(), $urandom()});
      io   = ($urandom_range(0, 3) == 0);
      hold = (i != 9) && ($urandom_range(0, 1) == 1);
      send(IW'($urandom()), d, io, l, IW'($urandom()), hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();

    // Abort a scan at bit 10 of SDR.
    send(2'b11, DW'({$urandom(), $urandom()}), 1'b0, DW'({$urandom(), $urandom()}), 2'b01, 1'b0);
    repeat (2 * P + 10 * P) @(posedge clk);
    #2;
    check("mid_sdr", sdr, 1'b1);
    rst = 1'b1;
    #1;
    check_reset_values();
    q.delete();
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0;
    model_rsp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    send(2'b01, DW'({$urandom(), $urandom()}), 1'b0, DW'({$urandom(), $urandom()}), 2'b10, 1'b0);
    drain();

    // TCK_DIV=1 instance: single-bit payload, shift order and latency.
    @(negedge clk);
    bus2.req_valid = 1'b1;
    bus2.req_data  = 38'h1;
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b0;
    n = 0; first_hi = 0; hi_cnt = 0; n_sdr2 = 0;
    do begin
      @(negedge clk);
      n++;
      if (sdr2) n_sdr2++;
      if (tdi2) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = n;
      end
    end while (!bus2.rsp_valid && n < 300);
    check("div1_latency", n, 83);
    check("div1_tdi_first", first_hi, 5);
    check("div1_tdi_count", hi_cnt, 2);
    check("div1_sdr_cycles", n_sdr2, 76);
    check("div1_rsp_data", bus2.rsp_data, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
